// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state type, default geometry and result bundle for hazard_scanner
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    RESOLVE = 2'd2
  } scan_state_t;

  localparam int DEF_NUM_LANES    = 13;
  localparam int DEF_OBJ_PER_LANE = 3;
  localparam int DEF_COORD_W      = 10;
  localparam int DEF_BLOCKSIZE    = 32;
  localparam int DEF_FROG_SIZE    = 32;
  localparam int DEF_LANE0_Y      = 32;
  localparam int DEF_PLAY_LEFT    = 96;
  localparam int DEF_PLAY_RIGHT   = 576;
  localparam int DEF_GOAL_Y       = 32;

  typedef struct packed {
    logic hit;
    logic on_log;
    logic in_water;
    logic off_screen;
    logic reached_end;
    logic collision;
  } result_t;

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - axis-aligned box overlap test with one guard bit so sums never wrap
module aabb_overlap #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] a_w,
  input  logic [COORD_W-1:0] a_h,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [COORD_W-1:0] b_w,
  input  logic [COORD_W-1:0] b_h,
  output logic               overlap,
  output logic               y_overlap
);

  logic [COORD_W:0] a_x_e, a_y_e, b_x_e, b_y_e;
  logic [COORD_W:0] a_right, a_bottom, b_right, b_bottom;
  logic             x_overlap;

  assign a_x_e    = {1'b0, a_x};
  assign a_y_e    = {1'b0, a_y};
  assign b_x_e    = {1'b0, b_x};
  assign b_y_e    = {1'b0, b_y};
  assign a_right  = a_x_e + {1'b0, a_w};
  assign a_bottom = a_y_e + {1'b0, a_h};
  assign b_right  = b_x_e + {1'b0, b_w};
  assign b_bottom = b_y_e + {1'b0, b_h};

  assign x_overlap = (a_x_e < b_right) && (a_right > b_x_e);
  assign y_overlap = (a_y_e < b_bottom) && (a_bottom > b_y_e);
  assign overlap   = x_overlap && y_overlap;

endmodule

// File: rtl/hazard_scanner.sv
// rtl/hazard_scanner.sv - time-multiplexed frog collision/hazard scanner, one object slot per clock
// Define HAZARD_SCANNER_LANE_MASK_EN to build the per-lane road hit mask; otherwise it reads 0.
module hazard_scanner
  import hazard_pkg::*;
#(
  parameter int NUM_LANES    = DEF_NUM_LANES,
  parameter int OBJ_PER_LANE = DEF_OBJ_PER_LANE,
  parameter int COORD_W      = DEF_COORD_W,
  parameter int BLOCKSIZE    = DEF_BLOCKSIZE,
  parameter int FROG_SIZE    = DEF_FROG_SIZE,
  parameter int LANE0_Y      = DEF_LANE0_Y,
  parameter int PLAY_LEFT    = DEF_PLAY_LEFT,
  parameter int PLAY_RIGHT   = DEF_PLAY_RIGHT,
  parameter int GOAL_Y       = DEF_GOAL_Y
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [COORD_W-1:0]                     frog_x,
  input  logic [COORD_W-1:0]                     frog_y,
  input  logic [NUM_LANES*OBJ_PER_LANE*COORD_W-1:0] obj_x,
  input  logic [NUM_LANES*OBJ_PER_LANE-1:0]      obj_valid,
  input  logic [NUM_LANES*COORD_W-1:0]           lane_len,
  input  logic [NUM_LANES-1:0]                   lane_is_water,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   hit,
  output logic                                   on_log,
  output logic                                   in_water,
  output logic                                   off_screen,
  output logic                                   reached_end,
  output logic                                   collision,
  output logic [$clog2(NUM_LANES)-1:0]           log_lane,
  output logic [NUM_LANES-1:0]                   hit_lane_mask
);

  localparam int N      = NUM_LANES * OBJ_PER_LANE;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int SLOT_W = (OBJ_PER_LANE > 1) ? $clog2(OBJ_PER_LANE) : 1;
  localparam int LANE_W = $clog2(NUM_LANES);

  scan_state_t state, next_state;
  logic scan_load, scan_en, resolve_en;

  logic [IDX_W-1:0]   idx;
  logic [SLOT_W-1:0]  slot;
  logic [LANE_W-1:0]  lane;
  logic [COORD_W-1:0] lane_y;
  logic [COORD_W-1:0] sx, sy;

  logic               acc_hit, acc_log, acc_water;
  logic [LANE_W-1:0]  acc_log_lane;
  result_t            res;

  logic [COORD_W-1:0] cur_x, cur_len;
  logic               cur_valid, cur_water;
  logic               raw_overlap, y_overlap, slot_overlap;
  logic [COORD_W:0]   sx_right;
  logic               off_now, goal_now, water_now;

  // Object data is sampled live, so each slot is read in its own scan cycle.
  assign cur_x     = obj_x[idx*COORD_W +: COORD_W];
  assign cur_valid = obj_valid[idx];
  assign cur_len   = lane_len[lane*COORD_W +: COORD_W];
  assign cur_water = lane_is_water[lane];

  aabb_overlap #(
    .COORD_W (COORD_W)
  ) u_overlap (
    .a_x       (sx),
    .a_y       (sy),
    .a_w       (COORD_W'(FROG_SIZE)),
    .a_h       (COORD_W'(FROG_SIZE)),
    .b_x       (cur_x),
    .b_y       (lane_y),
    .b_w       (cur_len),
    .b_h       (COORD_W'(BLOCKSIZE)),
    .overlap   (raw_overlap),
    .y_overlap (y_overlap)
  );

  assign slot_overlap = raw_overlap && cur_valid;

  assign sx_right  = {1'b0, sx} + (COORD_W+1)'(FROG_SIZE);
  assign off_now   = (sx_right <= (COORD_W+1)'(PLAY_LEFT)) ||
                     ({1'b0, sx} >= (COORD_W+1)'(PLAY_RIGHT));
  assign goal_now  = ({1'b0, sy} < (COORD_W+1)'(GOAL_Y));
  assign water_now = acc_water && !acc_log;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    scan_load  = 1'b0;
    scan_en    = 1'b0;
    resolve_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SCAN;
          scan_load  = 1'b1;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx == IDX_W'(N-1)) begin
          next_state = RESOLVE;
        end
      end
      RESOLVE: begin
        resolve_en = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      slot         <= '0;
      lane         <= '0;
      lane_y       <= '0;
      sx           <= '0;
      sy           <= '0;
      acc_hit      <= 1'b0;
      acc_log      <= 1'b0;
      acc_water    <= 1'b0;
      acc_log_lane <= '0;
    end else if (scan_load) begin
      idx          <= '0;
      slot         <= '0;
      lane         <= '0;
      lane_y       <= COORD_W'(LANE0_Y);
      sx           <= frog_x;
      sy           <= frog_y;
      acc_hit      <= 1'b0;
      acc_log      <= 1'b0;
      acc_water    <= 1'b0;
      acc_log_lane <= '0;
    end else if (scan_en) begin
      idx <= idx + 1'b1;
      // Lane base y walks with the lane counter instead of multiplying.
      if (slot == SLOT_W'(OBJ_PER_LANE-1)) begin
        slot   <= '0;
        lane   <= lane + 1'b1;
        lane_y <= lane_y + COORD_W'(BLOCKSIZE);
      end else begin
        slot <= slot + 1'b1;
      end
      if (slot_overlap) begin
        if (cur_water) begin
          acc_log <= 1'b1;
          if (!acc_log) begin
            acc_log_lane <= lane;
          end
        end else begin
          acc_hit <= 1'b1;
        end
      end
      if (cur_water && y_overlap) begin
        acc_water <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      res      <= '0;
      log_lane <= '0;
    end else begin
      done <= resolve_en;
      if (resolve_en) begin
        res.hit         <= acc_hit;
        res.on_log      <= acc_log;
        res.in_water    <= water_now;
        res.off_screen  <= off_now;
        res.reached_end <= goal_now;
        res.collision   <= acc_hit || water_now || off_now;
        log_lane        <= acc_log_lane;
      end
    end
  end

`ifdef HAZARD_SCANNER_LANE_MASK_EN
  logic [NUM_LANES-1:0] acc_mask, mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_mask <= '0;
      mask_q   <= '0;
    end else begin
      if (scan_load) begin
        acc_mask <= '0;
      end else if (scan_en && slot_overlap && !cur_water) begin
        acc_mask[lane] <= 1'b1;
      end
      if (resolve_en) begin
        mask_q <= acc_mask;
      end
    end
  end

  assign hit_lane_mask = mask_q;
`else
  assign hit_lane_mask = '0;
`endif

  assign busy        = (state != IDLE);
  assign hit         = res.hit;
  assign on_log      = res.on_log;
  assign in_water    = res.in_water;
  assign off_screen  = res.off_screen;
  assign reached_end = res.reached_end;
  assign collision   = res.collision;

endmodule

// File: tb/tb_hazard_scanner.sv
// tb/tb_hazard_scanner.sv - directed self-checking bench for hazard_scanner
module tb_hazard_scanner;

  localparam int NL = 13;
  localparam int OP = 3;
  localparam int CW = 10;
  localparam int NS = NL * OP;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [CW-1:0]      frog_x, frog_y;
  logic [NS*CW-1:0]   obj_x;
  logic [NS-1:0]      obj_valid;
  logic [NL*CW-1:0]   lane_len;
  logic [NL-1:0]      lane_is_water;
  logic               busy, done, hit, on_log, in_water, off_screen, reached_end, collision;
  logic [3:0]         log_lane;
  logic [NL-1:0]      hit_lane_mask;

  int checks = 0;
  int errors = 0;
  int lat;
  logic busy_mid;
  int done_cnt;
  logic [NL-1:0] exp_mask;

  hazard_scanner dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .frog_x        (frog_x),
    .frog_y        (frog_y),
    .obj_x         (obj_x),
    .obj_valid     (obj_valid),
    .lane_len      (lane_len),
    .lane_is_water (lane_is_water),
    .busy          (busy),
    .done          (done),
    .hit           (hit),
    .on_log        (on_log),
    .in_water      (in_water),
    .off_screen    (off_screen),
    .reached_end   (reached_end),
    .collision     (collision),
    .log_lane      (log_lane),
    .hit_lane_mask (hit_lane_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start and counts clock edges from the accepting edge to done (0 = timeout).
  task automatic run_scan(input bit extra_start, input bit no_wait);
    if (!no_wait) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_mid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 5) busy_mid = busy;
      if (extra_start && c == 10) start = 1'b1;
      if (extra_start && c == 11) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic set_slot(input int k, input int x, input bit v);
    obj_x[k*CW +: CW] = CW'(x);
    obj_valid[k] = v;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    frog_x = '0;
    frog_y = '0;
    obj_x = '0;
    obj_valid = '0;
    lane_len = '0;
    lane_is_water = '0;
`ifdef HAZARD_SCANNER_LANE_MASK_EN
    exp_mask = 13'h0080;
`else
    exp_mask = 13'h0000;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_collision", collision, 0);
    chk("reset_mask", hit_lane_mask, 0);
    reset_n = 1'b1;

    // No objects
    frog_x = 320; frog_y = 448;
    run_scan(0, 0);
    chk("empty_latency", lat, 40);
    chk("empty_busy_mid", busy_mid, 1);
    chk("empty_flags", {hit, on_log, in_water, off_screen, reached_end, collision}, 0);
    @(negedge clk);
    chk("empty_busy_after", busy, 0);
    chk("empty_done_pulse", done, 0);

    // Road hit, lane 7 slot 0 = slot 21
    lane_len[7*CW +: CW] = 64;
    set_slot(21, 300, 1);
    frog_x = 320; frog_y = 256;
    run_scan(0, 0);
    chk("road_latency", lat, 40);
    chk("road_hit", hit, 1);
    chk("road_collision", collision, 1);
    chk("road_mask", hit_lane_mask, exp_mask);
    chk("road_on_log", on_log, 0);

    // Back-to-back: start in the cycle right after done
    run_scan(0, 1);
    chk("b2b_latency", lat, 40);
    chk("b2b_hit", hit, 1);

    // No wrap on object right edge: 1000+64 must not fold to 40
    set_slot(21, 1000, 1);
    frog_x = 20;
    run_scan(0, 0);
    chk("nowrap_low_hit", hit, 0);
    frog_x = 1010;
    run_scan(0, 0);
    chk("nowrap_high_hit", hit, 1);
    chk("nowrap_high_off", off_screen, 1);
    set_slot(21, 0, 0);

    // Log carry, lane 0 water
    lane_is_water[0] = 1'b1;
    lane_len[0 +: CW] = 96;
    set_slot(0, 300, 1);
    frog_x = 320; frog_y = 32;
    run_scan(0, 0);
    chk("log_on_log", on_log, 1);
    chk("log_lane0", log_lane, 0);
    chk("log_in_water", in_water, 0);
    chk("log_collision", collision, 0);
    set_slot(0, 300, 0);
    run_scan(0, 0);
    chk("water_on_log", on_log, 0);
    chk("water_in_water", in_water, 1);
    chk("water_collision", collision, 1);

    // Frog straddles lanes 0 and 1 (y 48), only lane 1 has a log
    lane_is_water[1] = 1'b1;
    lane_len[1*CW +: CW] = 96;
    set_slot(3, 300, 1);
    frog_y = 48;
    run_scan(0, 0);
    chk("log1_on_log", on_log, 1);
    chk("log1_lane", log_lane, 1);
    chk("log1_in_water", in_water, 0);
    set_slot(3, 0, 0);
    lane_is_water = '0;

    // Playfield edges
    frog_x = 64; frog_y = 448;
    run_scan(0, 0);
    chk("edge64_off", off_screen, 1);
    chk("edge64_collision", collision, 1);
    frog_x = 96;
    run_scan(0, 0);
    chk("edge96_off", off_screen, 0);
    frog_x = 575;
    run_scan(0, 0);
    chk("edge575_off", off_screen, 0);
    frog_x = 576;
    run_scan(0, 0);
    chk("edge576_off", off_screen, 1);
    frog_x = 320; frog_y = 0;
    run_scan(0, 0);
    chk("goal_reached", reached_end, 1);
    chk("goal_collision", collision, 0);
    frog_y = 32;
    run_scan(0, 0);
    chk("goal_not_reached", reached_end, 0);

    // start mid-scan ignored
    lane_len[7*CW +: CW] = 64;
    set_slot(21, 300, 1);
    frog_x = 320; frog_y = 256;
    run_scan(1, 0);
    chk("midstart_latency", lat, 40);
    chk("midstart_hit", hit, 1);
    done_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midstart_no_second_done", done_cnt, 0);
    chk("midstart_idle", busy, 0);

    // Reset mid-scan
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_collision", collision, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    run_scan(0, 0);
    chk("rst_restart_latency", lat, 40);
    chk("rst_restart_hit", hit, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
